codec_rx_deinterleave: RTL
==========================

Name: codec_rx_deinterleave

Overview:
Parametrised RX codec front-end stage placed between the IDDR2 capture flops and the radio core. It takes the two half-cycle ADC captures and their two RXSYNC captures, and tracks the interleave phase with a lock/unlock state machine. It emits registered, phase-corrected I/Q samples, with runtime inversion and I/Q swap. It also reports lock status, a sticky lock-loss flag and a saturating sync-error counter.

Parameters:
WIDTH, 12, ADC sample width in bits.
LOCK_CYCLES, 4, consecutive valid same-phase frames needed to lock; must be 2 or more.
UNLOCK_CYCLES, 3, consecutive bad frames while locked that force unlock; must be 1 or more.
ERR_CNT_WIDTH, 16, width of the saturating error counter.

Ports:
clk  in  1  sample clock
reset  in  1  asynchronous, active-high
clear  in  1  synchronous clear of err_count and lock_lost
invert  in  1  1 = bitwise-invert both output samples
swap_iq  in  1  1 = exchange I and Q after phase correction
rx_a  in  WIDTH  capture on rising edge (IDDR2 Q0)
rx_b  in  WIDTH  capture on falling edge (IDDR2 Q1)
rxsync_0  in  1  RXSYNC captured on rising edge
rxsync_1  in  1  RXSYNC captured on falling edge
rx_i  out  WIDTH  registered I sample
rx_q  out  WIDTH  registered Q sample
rx_valid  out  1  high while locked
locked  out  1  state is LOCKED
locked_phase  out  1  latched phase; 1 = rx_b carries I
err_count  out  ERR_CNT_WIDTH  saturating count of bad frames seen while LOCKED
lock_lost  out  1  sticky; set on each LOCKED->UNLOCKED transition

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted, all outputs are 0, the state is UNLOCKED and all internal counters are 0.
- Frame valid: v = rxsync_0 ^ rxsync_1. Frame phase: p = rxsync_0.
- Phase select:
  - In LOCKED, ph = locked_phase. In all other states, ph = p (legacy pass-through).
  - ph = 1: i_raw = rx_b, q_raw = rx_a.
  - ph = 0: i_raw = rx_a, q_raw = rx_b.
- Inversion and swap:
  - If invert = 1: i_raw = ~i_raw and q_raw = ~q_raw.
  - If swap_iq = 1: I and Q are exchanged after inversion.
- Data latency: exactly 1 clk from rx_a/rx_b to rx_i/rx_q. There is no backpressure, and outputs update every cycle.
- UNLOCKED:
  - v = 1: cand <= p, cnt <= 1, go to ACQUIRE.
  - v = 0: stay, cnt <= 0.
- ACQUIRE:
  - v = 1 and p == cand: cnt <= cnt + 1. When cnt + 1 == LOCK_CYCLES, go to LOCKED and set locked_phase <= cand, miss <= 0.
  - v = 1 and p != cand: cand <= p, cnt <= 1, stay in ACQUIRE.
  - v = 0: go to UNLOCKED, cnt <= 0.
- LOCKED:
  - A good frame is v = 1 and p == locked_phase. It sets miss <= 0.
  - Any other frame is bad. It increments err_count (saturating at all-ones) and miss <= miss + 1.
  - When miss + 1 == UNLOCK_CYCLES: go to UNLOCKED, set lock_lost <= 1, miss <= 0.
- Status outputs:
  - locked and rx_valid are registered state decodes, high starting the cycle after the LOCK_CYCLES-th good edge.
  - During bad frames that do not unlock, data keeps using locked_phase and rx_valid stays high.
  - locked_phase holds its value after unlock until the next lock.
- Simultaneous events:
  - clear together with an error increment: err_count becomes 0 (clear wins).
  - clear together with a lock-loss event: lock_lost becomes 1 (set wins).
- Reset during ACQUIRE or LOCKED returns immediately to the reset values. No partial count survives.
- cnt and miss are sized as clog2 of their respective limit + 1.

Test Plan:
1. Reset mid-stream: lock the block, then pulse reset between clock edges. All outputs go to 0 asynchronously, and the block is UNLOCKED after release.
2. Acquire: rxsync_0 = 1, rxsync_1 = 0, rx_a = 12'h123, rx_b = 12'h456, invert = 0, swap_iq = 0, held for 4 cycles. Response: locked = 1 and rx_valid = 1 after the 4th edge, locked_phase = 1, rx_i = 12'h456, rx_q = 12'h123.
3. Invert and swap: continue test 2, then set invert = 1. Response: rx_i = 12'hBA9, rx_q = 12'hEDC. Then set swap_iq = 1. Response: rx_i = 12'hEDC, rx_q = 12'hBA9. Each change appears 1 cycle later.
4. Phase change during acquire: 3 frames with phase 1, then phase 0 frames. Acquisition restarts, and locked = 1 with locked_phase = 0 only after the 4th phase-0 frame (7 frames total). An invalid frame (rxsync both 0) during ACQUIRE returns the block to UNLOCKED.
5. Glitch tolerance: while locked with phase 1, send 2 frames with rxsync = 00, then 1 good frame. Response: stays locked, err_count = 2, data still uses rx_b as I. Next, send 3 consecutive bad frames. Response: locked = 0, lock_lost = 1, err_count = 5.
6. Saturation and clear, with ERR_CNT_WIDTH = 4: while locked, alternate bad and good frames for 40 cycles. Response: err_count = 15 (saturated) and locked stays high. Then pulse clear in the same cycle as a bad frame. Response: err_count = 0.

Source files
------------

// File: rtl/codec_rx_deinterleave.sv
// RX codec front-end: de-interleaves IDDR2 half-cycle ADC captures into I/Q
// using RXSYNC, with a lock/unlock tracker, inversion/swap and error stats.
module codec_rx_deinterleave #(
    parameter int WIDTH         = 12,
    parameter int LOCK_CYCLES   = 4,
    parameter int UNLOCK_CYCLES = 3,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     invert,
    input  logic                     swap_iq,
    input  logic [WIDTH-1:0]         rx_a,
    input  logic [WIDTH-1:0]         rx_b,
    input  logic                     rxsync_0,
    input  logic                     rxsync_1,
    output logic [WIDTH-1:0]         rx_i,
    output logic [WIDTH-1:0]         rx_q,
    output logic                     rx_valid,
    output logic                     locked,
    output logic                     locked_phase,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic                     lock_lost
);

    localparam int CNT_W  = $clog2(LOCK_CYCLES + 1);
    localparam int MISS_W = $clog2(UNLOCK_CYCLES + 1);

    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic [MISS_W-1:0]   miss, miss_next;
    logic                cand, cand_next;
    logic                phase_next;
    logic                bad_frame;
    logic                lose_lock;
    logic                frame_valid;
    logic                frame_phase;
    logic                ph;
    logic [WIDTH-1:0]    i_sel, q_sel, i_out, q_out;

    always_comb begin
        frame_valid = rxsync_0 ^ rxsync_1;
        frame_phase = rxsync_0;
        state_next  = state;
        cnt_next    = cnt;
        cand_next   = cand;
        miss_next   = miss;
        phase_next  = locked_phase;
        bad_frame   = 1'b0;
        lose_lock   = 1'b0;
        case (state)
            UNLOCKED: begin
                if (frame_valid) begin
                    cand_next  = frame_phase;
                    cnt_next   = CNT_W'(1);
                    state_next = ACQUIRE;
                end else begin
                    cnt_next = '0;
                end
            end
            ACQUIRE: begin
                if (!frame_valid) begin
                    state_next = UNLOCKED;
                    cnt_next   = '0;
                end else if (frame_phase == cand) begin
                    if (cnt == CNT_W'(LOCK_CYCLES - 1)) begin
                        state_next = LOCKED;
                        phase_next = cand;
                        miss_next  = '0;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end else begin
                    // Phase moved mid-acquisition: restart the run on the new phase
                    cand_next = frame_phase;
                    cnt_next  = CNT_W'(1);
                end
            end
            LOCKED: begin
                if (frame_valid && (frame_phase == locked_phase)) begin
                    miss_next = '0;
                end else begin
                    bad_frame = 1'b1;
                    if (miss == MISS_W'(UNLOCK_CYCLES - 1)) begin
                        lose_lock  = 1'b1;
                        state_next = UNLOCKED;
                        miss_next  = '0;
                    end else begin
                        miss_next = miss + MISS_W'(1);
                    end
                end
            end
            default: state_next = UNLOCKED;
        endcase
    end

    always_comb begin
        ph    = (state == LOCKED) ? locked_phase : rxsync_0;
        i_sel = ph ? rx_b : rx_a;
        q_sel = ph ? rx_a : rx_b;
        if (invert) begin
            i_sel = ~i_sel;
            q_sel = ~q_sel;
        end
        i_out = swap_iq ? q_sel : i_sel;
        q_out = swap_iq ? i_sel : q_sel;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= UNLOCKED;
            cnt          <= '0;
            miss         <= '0;
            cand         <= 1'b0;
            locked_phase <= 1'b0;
            locked       <= 1'b0;
            rx_valid     <= 1'b0;
            rx_i         <= '0;
            rx_q         <= '0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            miss         <= miss_next;
            cand         <= cand_next;
            locked_phase <= phase_next;
            locked       <= (state_next == LOCKED);
            rx_valid     <= (state_next == LOCKED);
            rx_i         <= i_out;
            rx_q         <= q_out;
        end
    end

    // Clear beats a simultaneous error increment, but a lock-loss event beats clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= '0;
            lock_lost <= 1'b0;
        end else begin
            if (clear)
                err_count <= '0;
            else if (bad_frame && (err_count != {ERR_CNT_WIDTH{1'b1}}))
                err_count <= err_count + ERR_CNT_WIDTH'(1);
            if (lose_lock)
                lock_lost <= 1'b1;
            else if (clear)
                lock_lost <= 1'b0;
        end
    end

endmodule
